// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the parallel-flash arbiter.
// Used by the arbiter, its watchdog and the bus interface.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } arb_state_e;

  localparam int FL_AW       = 23;
  localparam int FL_DW       = 16;
  localparam int TIMEOUT_DEF = 255;

  localparam logic [15:0] FILL_WORD = 16'hFFFF;

endpackage

// File: rtl/flash_arbiter_if.sv
// Requester-side and flash-side signals of the flash arbiter, bundled in one interface.
// slave = arbiter view; master = the environment driving requests and the flash controller.
interface flash_arbiter_if import flash_arb_pkg::*; #(
  parameter int AW = FL_AW,
  parameter int DW = FL_DW
) ();

  logic          ireq0;
  logic          ireq1;
  logic [AW-1:0] iaddr0;
  logic [AW-1:0] iaddr1;
  logic          ilock0;
  logic          oack0;
  logic          oack1;
  logic [DW-1:0] odata0;
  logic [DW-1:0] odata1;
  logic          oerr0;
  logic          oerr1;
  logic          ofl_req;
  logic [AW-1:0] ofl_addr;
  logic [DW-1:0] ifl_data;
  logic          ifl_ack;
  logic [1:0]    ogrant;

  modport slave (
    input  ireq0, ireq1, iaddr0, iaddr1, ilock0, ifl_data, ifl_ack,
    output oack0, oack1, odata0, odata1, oerr0, oerr1, ofl_req, ofl_addr, ogrant
  );

  modport master (
    output ireq0, ireq1, iaddr0, iaddr1, ilock0, ifl_data, ifl_ack,
    input  oack0, oack1, odata0, odata1, oerr0, oerr1, ofl_req, ofl_addr, ogrant
  );

endinterface

// File: rtl/flash_arb_wdog.sv
// 8-bit clear/enable watchdog counter for an outstanding flash request.
// oexpired is high during the TIMEOUT-th cycle the request has been outstanding.
module flash_arb_wdog import flash_arb_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic iclk,
  input  logic ireset_n,
  input  logic iclr,
  input  logic ien,
  output logic oexpired
);

  // Count starts at 0 in the first request cycle, so TIMEOUT-1 marks the last one.
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      cnt_q <= '0;
    end else if (iclr) begin
      cnt_q <= '0;
    end else if (ien) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign oexpired = (cnt_q == LAST);

endmodule

// File: rtl/flash_arbiter.sv
// Two-port round-robin arbiter in front of the flash controller word port,
// with a port-0 lock and a watchdog that completes hung reads with an error.
module flash_arbiter import flash_arb_pkg::*; #(
  parameter int AW      = FL_AW,
  parameter int DW      = FL_DW,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             iclk,
  input  logic             ireset_n,
  flash_arbiter_if.slave   bus
);

  arb_state_e    state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;      // 1: port 1 was granted last
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] data0_q, data0_d;
  logic [DW-1:0] data1_q, data1_d;
  logic          wd_clr, wd_en, wd_hit;
  logic          pick0, done_now;
  logic [DW-1:0] rd_word;

  flash_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .iclr     (wd_clr),
    .ien      (wd_en),
    .oexpired (wd_hit)
  );

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    addr_d   = addr_q;
    req_d    = req_q;
    ack_d    = '0;
    err_d    = '0;
    data0_d  = '0;
    data1_d  = '0;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    done_now = 1'b0;
    rd_word  = bus.ifl_data;
    // Lock, a lone request, or a tie after port 1's turn all go to port 0.
    pick0    = bus.ireq0 && (bus.ilock0 || !bus.ireq1 || last_q);

    unique case (state_q)
      IDLE: begin
        if (bus.ireq0 || bus.ireq1) begin
          grant_d = pick0 ? 2'b01 : 2'b10;
          addr_d  = pick0 ? bus.iaddr0 : bus.iaddr1;
          req_d   = 1'b1;
          wd_clr  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.ifl_ack) begin
          done_now = 1'b1;
        end else if (wd_hit) begin
          done_now = 1'b1;
          rd_word  = DW'(FILL_WORD);
          err_d    = grant_q;
        end else begin
          wd_en = 1'b1;
        end
        if (done_now) begin
          req_d   = 1'b0;
          ack_d   = grant_q;
          data0_d = grant_q[0] ? rd_word : '0;
          data1_d = grant_q[1] ? rd_word : '0;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = grant_q[1];
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      req_q   <= 1'b0;
      ack_q   <= '0;
      err_q   <= '0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  assign bus.ofl_req  = req_q;
  assign bus.ofl_addr = addr_q;
  assign bus.ogrant   = grant_q;
  assign bus.oack0    = ack_q[0];
  assign bus.oack1    = ack_q[1];
  assign bus.oerr0    = err_q[0];
  assign bus.oerr1    = err_q[1];
  assign bus.odata0   = data0_q;
  assign bus.odata1   = data1_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Self-checking bench for flash_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_flash_arbiter;
  import flash_arb_pkg::*;

  localparam int TIMEOUT = 8;

  logic iclk     = 1'b0;
  logic ireset_n = 1'b1;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   last_port = 1;   // model: port granted by the previous transaction

  flash_arbiter_if #(.AW(FL_AW), .DW(FL_DW)) bus ();

  flash_arbiter #(.AW(FL_AW), .DW(FL_DW), .TIMEOUT(TIMEOUT)) dut (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .bus      (bus)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arbitration rules: lock or lone port 0 -> 0; tie -> whoever was not last; else 1.
  function automatic int model_pick(input bit r0, input bit r1, input bit lk, input int last);
    if (r0 && lk) return 0;
    if (r0 && r1) return (last == 0) ? 1 : 0;
    if (r0)       return 0;
    return 1;
  endfunction

  // Runs one transaction from an IDLE cycle (cycle 0) up to the following IDLE cycle.
  // ack_cyc: cycle in which the flash acks (0 = never).
  task automatic xact(input bit r0, input bit r1, input bit lk,
                      input logic [FL_AW-1:0] a0, input logic [FL_AW-1:0] a1,
                      input int ack_cyc, input logic [FL_DW-1:0] d, input int exp_port);
    int done_cyc;
    bit exp_err;
    logic [FL_DW-1:0] exp_data;
    logic [FL_AW-1:0] exp_addr;
    logic [1:0] exp_grant;
    exp_err   = !(ack_cyc >= 1 && ack_cyc <= TIMEOUT);
    done_cyc  = exp_err ? TIMEOUT + 1 : ack_cyc + 1;
    exp_data  = exp_err ? 16'hFFFF : d;
    exp_addr  = (exp_port == 0) ? a0 : a1;
    exp_grant = (exp_port == 0) ? 2'b01 : 2'b10;

    check("req_low_before", 32'(bus.ofl_req), 32'd0);
    bus.ireq0 = r0; bus.ireq1 = r1; bus.ilock0 = lk;
    bus.iaddr0 = a0; bus.iaddr1 = a1;
    for (int c = 1; c <= done_cyc; c++) begin
      @(negedge iclk);
      bus.ifl_ack  = 1'b0;
      bus.ifl_data = 16'($urandom);
      if (c < done_cyc) begin
        check("ofl_req", 32'(bus.ofl_req), 32'd1);
        check("ofl_addr", 32'(bus.ofl_addr), 32'(exp_addr));
        check("ogrant", 32'(bus.ogrant), 32'(exp_grant));
        check("no_early_ack", 32'({bus.oack1, bus.oack0}), 32'd0);
      end else begin
        check("oack_win", 32'(exp_port == 0 ? bus.oack0 : bus.oack1), 32'd1);
        check("oerr_win", 32'(exp_port == 0 ? bus.oerr0 : bus.oerr1), 32'(exp_err));
        check("odata_win", 32'(exp_port == 0 ? bus.odata0 : bus.odata1), 32'(exp_data));
        check("oack_other", 32'(exp_port == 0 ? bus.oack1 : bus.oack0), 32'd0);
        check("odata_other", 32'(exp_port == 0 ? bus.odata1 : bus.odata0), 32'd0);
        check("req_dropped", 32'(bus.ofl_req), 32'd0);
        check("ogrant_done", 32'(bus.ogrant), 32'(exp_grant));
        bus.ireq0 = 1'b0; bus.ireq1 = 1'b0;
      end
      if (c == ack_cyc) begin
        bus.ifl_ack  = 1'b1;
        bus.ifl_data = d;
      end
    end
    @(negedge iclk);
    bus.ifl_ack = 1'b0;
    check("idle_grant", 32'(bus.ogrant), 32'd0);
    check("idle_ack", 32'({bus.oack1, bus.oack0}), 32'd0);
    last_port = exp_port;
  endtask

  initial begin
    bus.ireq0 = 1'b0; bus.ireq1 = 1'b0; bus.ilock0 = 1'b0;
    bus.iaddr0 = '0; bus.iaddr1 = '0;
    bus.ifl_ack = 1'b0; bus.ifl_data = '0;

    // Reset values
    #1 ireset_n = 1'b0;
    @(negedge iclk);
    check("rst_req", 32'(bus.ofl_req), 32'd0);
    check("rst_addr", 32'(bus.ofl_addr), 32'd0);
    check("rst_grant", 32'(bus.ogrant), 32'd0);
    check("rst_ack", 32'({bus.oack1, bus.oack0}), 32'd0);
    check("rst_err", 32'({bus.oerr1, bus.oerr0}), 32'd0);
    check("rst_data", 32'({bus.odata1, bus.odata0}), 32'd0);
    ireset_n = 1'b1;
    @(negedge iclk);

    // Ties after reset alternate starting with port 0
    xact(1, 1, 0, 23'h000010, 23'h000020, 2, 16'h1111, 0);
    xact(1, 1, 0, 23'h000030, 23'h000040, 1, 16'h2222, 1);
    xact(1, 1, 0, 23'h000050, 23'h000060, 4, 16'h3333, 0);

    // Single read, ack in cycle 3
    xact(1, 0, 0, 23'h000100, 23'h000000, 3, 16'hA55A, 0);

    // Lock holds port 0 for four words, then port 1 wins the next tie
    for (int i = 0; i < 4; i++)
      xact(1, 1, 1, 23'(24'h200 + i), 23'h000300, 2, 16'(16'h4000 + i), 0);
    xact(1, 1, 0, 23'h000400, 23'h000500, 2, 16'h5A5A, 1);

    // Timeout on port 1, then a stray ack three cycles after oack
    xact(0, 1, 0, 23'h000000, 23'h0ABCDE, 0, 16'h0000, 1);
    @(negedge iclk);
    @(negedge iclk);
    bus.ifl_ack = 1'b1; bus.ifl_data = 16'h1234;
    @(negedge iclk);
    bus.ifl_ack = 1'b0;
    check("stray_ack1", 32'(bus.oack1), 32'd0);
    check("stray_ack0", 32'(bus.oack0), 32'd0);
    check("stray_req", 32'(bus.ofl_req), 32'd0);

    // Randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      bit r0, r1, lk;
      r0 = 1'($urandom);
      r1 = r0 ? 1'($urandom) : 1'b1;
      lk = ($urandom_range(0, 3) == 0);
      xact(r0, r1, lk, 23'($urandom), 23'($urandom),
           int'($urandom_range(0, TIMEOUT + 1)), 16'($urandom),
           model_pick(r0, r1, lk, last_port));
    end

    // Asynchronous reset while a request is outstanding
    bus.ireq0 = 1'b1; bus.ireq1 = 1'b0; bus.ilock0 = 1'b0; bus.iaddr0 = 23'h055555;
    @(negedge iclk);
    check("pre_rst_req", 32'(bus.ofl_req), 32'd1);
    @(negedge iclk);
    #2 ireset_n = 1'b0;
    #1;
    check("async_rst_req", 32'(bus.ofl_req), 32'd0);
    check("async_rst_grant", 32'(bus.ogrant), 32'd0);
    bus.ireq0 = 1'b0;
    bus.ifl_ack = 1'b1;
    @(negedge iclk);
    bus.ifl_ack = 1'b0;
    ireset_n = 1'b1;
    last_port = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge iclk);
      check("no_ack_after_rst", 32'({bus.oack1, bus.oack0}), 32'd0);
      check("no_req_after_rst", 32'(bus.ofl_req), 32'd0);
    end
    xact(1, 1, 0, 23'h000777, 23'h000888, 3, 16'hBEEF, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
